// File: rtl/counter_updown_mod_if.sv
// ----------------------------------------------------------------------------
// counter_updown_mod_if
// Purpose : groups the control/status signals of counter_updown_mod so that
//           the counter and its user connect through one bundle.
// Signals : en         count enable (gates stepping only)
//           load       parallel load request
//           load_data  value to load (clamped to limit by the counter)
//           up         direction, 1 = increment, 0 = decrement
//           limit      modulo top value, sampled every cycle
//           wrap       1 = wrap at boundary, 0 = saturate
//           oneshot    1 = one-shot mode, 0 = free-running
//           start      one-shot launch request
//           count      current count (registered)
//           tc         terminal-count pulse (registered, 1 cycle)
//           busy       one-shot run in progress
//           done       one-shot completion pulse (1 cycle)
// Modports: master drives the controls and observes status,
//           slave is the counter side.
// ----------------------------------------------------------------------------
interface counter_updown_mod_if #(
    parameter int n = 4
);
    logic         en;
    logic         load;
    logic [n-1:0] load_data;
    logic         up;
    logic [n-1:0] limit;
    logic         wrap;
    logic         oneshot;
    logic         start;
    logic [n-1:0] count;
    logic         tc;
    logic         busy;
    logic         done;

    modport master (
        output en, load, load_data, up, limit, wrap, oneshot, start,
        input  count, tc, busy, done
    );

    modport slave (
        input  en, load, load_data, up, limit, wrap, oneshot, start,
        output count, tc, busy, done
    );
endinterface

// File: rtl/counter_updown_mod.sv
// ----------------------------------------------------------------------------
// counter_updown_mod
// Purpose : general timer/event counter. Up/down counting against a runtime
//           modulo limit, wrap or saturate at the boundary, a one-cycle
//           terminal-count pulse and a one-shot mode sequenced by an
//           IDLE/RUN/DONE state machine.
// Ports   : clk     rising-edge clock
//           resetn  synchronous active-low reset
//           bus     counter_updown_mod_if.slave (controls in, count/status out)
// Parameter n : counter width; count range is 0..limit.
// ----------------------------------------------------------------------------
module counter_updown_mod #(
    parameter int n = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    counter_updown_mod_if.slave       bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t       r_state;
    logic [n-1:0] r_count;
    logic         r_tc;
    logic         r_busy;
    logic         r_done;

    logic         w_advance;
    logic         w_wrap_eff;
    logic [n-1:0] w_step;
    logic [n-1:0] w_bnd;
    logic [n-1:0] w_load_val;
    logic         w_tc_next;

    // One-shot mode only steps while a run is in progress.
    assign w_advance  = bus.en & ~bus.load &
                        (bus.oneshot ? (r_state == ST_RUN) : 1'b1);
    // A one-shot run always stops at the boundary, whatever wrap says.
    assign w_wrap_eff = bus.wrap & ~bus.oneshot;
    assign w_bnd      = bus.up ? bus.limit : '0;
    assign w_load_val = (bus.load_data > bus.limit) ? bus.limit : bus.load_data;

    // Candidate next count when stepping.
    always_comb begin
        w_step = r_count;
        if (r_count > bus.limit) begin
            // limit was lowered below the current count: pull back in range
            w_step = (w_wrap_eff & bus.up) ? '0 : bus.limit;
        end else if (bus.up) begin
            if (r_count == bus.limit)
                w_step = w_wrap_eff ? '0 : bus.limit;
            else
                w_step = r_count + 1'b1;
        end else begin
            if (r_count == '0)
                w_step = w_wrap_eff ? bus.limit : '0;
            else
                w_step = r_count - 1'b1;
        end
    end

    // tc only on a real arrival at the boundary, so a held saturated count
    // (or limit==0) never repeats the pulse.
    assign w_tc_next = w_advance & (w_step == w_bnd) & (w_step != r_count);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (bus.load) begin
            // load aborts any run silently
            r_count <= w_load_val;
            r_tc    <= 1'b0;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            if (w_advance)
                r_count <= w_step;
            r_tc <= w_tc_next;

            if (!bus.oneshot) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_busy  <= 1'b0;
                        end
                        r_done <= 1'b0;
                    end
                    ST_RUN: begin
                        if (w_tc_next) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.count = r_count;
    assign bus.tc    = r_tc;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;

endmodule

// File: tb/tb_counter_updown_mod.sv
// ----------------------------------------------------------------------------
// tb_counter_updown_mod
// Directed scenarios followed by randomized traffic. Every cycle the DUT
// outputs are compared with a behavioural model built on integer arithmetic.
// ----------------------------------------------------------------------------
module tb_counter_updown_mod;
    localparam int N = 4;

    logic clk;
    logic resetn;

    counter_updown_mod_if #(.n(N)) bus ();

    counter_updown_mod #(.n(N)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int tc_hits;

    // reference model state
    int m_count = 0;
    bit m_tc    = 1'b0;
    bit m_run   = 1'b0;
    bit m_done  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    // Behavioural model, evaluated with the inputs present at the clock edge.
    task automatic model_step();
        int lim;
        int nxt;
        int tgt;
        bit act;
        bit wrp;
        lim = int'(bus.limit);
        if (!resetn) begin
            m_count = 0; m_tc = 0; m_run = 0; m_done = 0;
        end else if (bus.load) begin
            m_count = (int'(bus.load_data) < lim) ? int'(bus.load_data) : lim;
            m_tc = 0; m_run = 0; m_done = 0;
        end else begin
            act = bus.en && (bus.oneshot ? m_run : 1'b1);
            wrp = bus.wrap && !bus.oneshot;
            if (m_count > lim)
                nxt = (wrp && bus.up) ? 0 : lim;
            else if (wrp)
                nxt = bus.up ? (m_count + 1) % (lim + 1) : (m_count + lim) % (lim + 1);
            else
                nxt = bus.up ? ((m_count < lim) ? m_count + 1 : lim)
                             : ((m_count > 0) ? m_count - 1 : 0);
            tgt  = bus.up ? lim : 0;
            m_tc = act && (nxt == tgt) && (nxt != m_count);
            if (act) m_count = nxt;
            if (!bus.oneshot) begin
                m_run = 0; m_done = 0;
            end else if (m_done) begin
                m_done = 0;
            end else if (m_run) begin
                if (m_tc) begin m_run = 0; m_done = 1; end
            end else if (bus.start) begin
                m_run = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        $display("[TB] cyc %0d rstn=%0b ld=%0b en=%0b up=%0b lim=%0d wr=%0b os=%0b st=%0b -> cnt=%0d tc=%0b busy=%0b done=%0b",
                 cyc, resetn, bus.load, bus.en, bus.up, bus.limit, bus.wrap, bus.oneshot,
                 bus.start, bus.count, bus.tc, bus.busy, bus.done);
        chk("count", 32'(bus.count), 32'(m_count));
        chk("tc",    32'(bus.tc),    32'(m_tc));
        chk("busy",  32'(bus.busy),  32'(m_run));
        chk("done",  32'(bus.done),  32'(m_done));
    endtask

    initial begin
        // 1: reset dominates en/load
        resetn = 1'b0; bus.en = 1'b1; bus.load = 1'b1; bus.load_data = N'(7);
        bus.up = 1'b1; bus.limit = N'(9); bus.wrap = 1'b1; bus.oneshot = 1'b0; bus.start = 1'b0;
        tick(); tick();
        chk("t1_rst_count", 32'(bus.count), 0);
        chk("t1_rst_flags", 32'({bus.tc, bus.busy, bus.done}), 0);
        resetn = 1'b1; bus.load = 1'b0;
        tick();
        chk("t1_first_step", 32'(bus.count), 1);

        // 2: up wrap, limit 9: 2..9,0,1 with one tc at 9
        tc_hits = 0;
        repeat (10) begin tick(); tc_hits += int'(bus.tc); end
        chk("t2_tc_per_period", 32'(tc_hits), 1);
        chk("t2_end_count", 32'(bus.count), 1);

        // 3: down saturate from 3
        bus.load = 1'b1; bus.load_data = N'(3); tick();
        bus.load = 1'b0; bus.up = 1'b0; bus.wrap = 1'b0;
        tc_hits = 0;
        repeat (5) begin tick(); tc_hits += int'(bus.tc); end
        chk("t3_tc_once", 32'(tc_hits), 1);
        chk("t3_sat_zero", 32'(bus.count), 0);
        bus.up = 1'b1; tick();
        chk("t3_dir_change", 32'(bus.count), 1);

        // 4: load clamp and lowered limit
        bus.en = 1'b0; bus.limit = N'(5); bus.load_data = N'(12); bus.load = 1'b1; tick();
        chk("t4_load_clamp", 32'(bus.count), 5);
        bus.load = 1'b0; bus.limit = N'(2); bus.wrap = 1'b1; bus.up = 1'b1; bus.en = 1'b1; tick();
        chk("t4_over_wrap", 32'(bus.count), 0);
        bus.en = 1'b0; bus.limit = N'(5); bus.load_data = N'(5); bus.load = 1'b1; tick();
        bus.load = 1'b0; bus.limit = N'(2); bus.wrap = 1'b0; bus.en = 1'b1; tick();
        chk("t4_over_sat", 32'(bus.count), 2);

        // 5: one-shot 0 -> 3
        bus.oneshot = 1'b1; bus.limit = N'(3); bus.load_data = N'(0); bus.load = 1'b1; tick();
        bus.load = 1'b0; bus.start = 1'b1; tick();
        chk("t5_launch_busy", 32'(bus.busy), 1);
        chk("t5_launch_hold", 32'(bus.count), 0);
        bus.start = 1'b0;
        tick(); tick(); tick();
        chk("t5_done_count", 32'(bus.count), 3);
        chk("t5_done_pulse", 32'(bus.done), 1);
        tick();
        chk("t5_idle_done", 32'(bus.done), 0);
        chk("t5_idle_count", 32'(bus.count), 3);
        // stretched run
        bus.load = 1'b1; tick();
        bus.load = 1'b0; bus.start = 1'b1; tick();
        bus.start = 1'b0; tick();
        bus.en = 1'b0; tick(); tick();
        chk("t5_stretch_busy", 32'(bus.busy), 1);
        chk("t5_stretch_count", 32'(bus.count), 1);
        bus.en = 1'b1; tick(); tick();
        chk("t5_stretch_done", 32'(bus.done), 1);
        tick();

        // 6: aborts and conflicts
        bus.load = 1'b1; bus.load_data = N'(0); tick();
        bus.load = 1'b0; bus.start = 1'b1; tick();
        bus.start = 1'b0; tick();
        bus.load = 1'b1; bus.load_data = N'(2); tick();
        chk("t6_abort_busy", 32'(bus.busy), 0);
        chk("t6_abort_count", 32'(bus.count), 2);
        bus.load = 1'b0; tick();
        chk("t6_abort_nodone", 32'(bus.done), 0);
        bus.load = 1'b1; bus.start = 1'b1; bus.load_data = N'(1); tick();
        bus.load = 1'b0; bus.start = 1'b0; tick();
        chk("t6_ldstart_idle", 32'(bus.busy), 0);
        chk("t6_ldstart_count", 32'(bus.count), 1);
        bus.load = 1'b1; bus.load_data = N'(0); tick();
        bus.load = 1'b0; bus.start = 1'b1; tick();
        bus.start = 1'b0; tick();
        resetn = 1'b0; tick();
        chk("t6_rst_midrun", 32'({bus.count, bus.tc, bus.busy, bus.done}), 0);
        resetn = 1'b1;

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            resetn        = ($urandom_range(0, 99) != 0);
            bus.load      = ($urandom_range(0, 19) == 0);
            bus.load_data = N'($urandom);
            bus.en        = ($urandom_range(0, 3) != 0);
            bus.start     = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0)  bus.up      = ~bus.up;
            if ($urandom_range(0, 15) == 0) bus.wrap    = ~bus.wrap;
            if ($urandom_range(0, 29) == 0) bus.oneshot = ~bus.oneshot;
            if ($urandom_range(0, 19) == 0) bus.limit   = N'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
